// File: rtl/conv_row_acc_pe_if.sv
// Streaming bus of the convolution PE: input beat channel (activations and
// weights) and output result channel, both valid/ready.
interface conv_row_acc_pe_if #(
   parameter int K      = 3,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [K*DATA_W-1:0]      in_data;
   logic [K*DATA_W-1:0]      weight;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [OUT_W-1:0]  out_data;
   logic signed [ACC_W-1:0]  out_acc;

   modport master (
      output in_valid, in_data, weight, out_ready,
      input  in_ready, out_valid, out_data, out_acc
   );

   modport slave (
      input  in_valid, in_data, weight, out_ready,
      output in_ready, out_valid, out_data, out_acc
   );
endinterface

// File: rtl/conv_row_acc_pe.sv
// Convolution processing element: K-tap multiply, row reduction, windowed
// accumulation over cfg_rows rows with bias, rounding shift, ReLU and
// saturation. Four register stages (products, row sum, accumulate, output),
// all frozen together while a result waits on out_ready.
module conv_row_acc_pe #(
   parameter int K      = 3,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              cfg_rows,
   input  logic [4:0]              cfg_shift,
   input  logic                    cfg_relu,
   input  logic signed [ACC_W-1:0] cfg_bias,
   conv_row_acc_pe_if.slave        pe_if
);

   localparam int PW = 2 * DATA_W;
   // Wide enough that the rounding constant for any 5-bit shift never overflows.
   localparam int RW = ACC_W + 33;
   localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   function automatic logic signed [RW-1:0] round_shift(input logic signed [ACC_W-1:0] a,
                                                        input logic [4:0] sh);
      logic signed [RW-1:0] ext;
      logic signed [RW-1:0] rnd;
      ext = {{(RW-ACC_W){a[ACC_W-1]}}, a};
      rnd = '0;
      if (sh != 5'd0) rnd = RW'(1) << (sh - 5'd1);
      return (ext + rnd) >>> sh;
   endfunction

   function automatic logic signed [OUT_W-1:0] saturate(input logic signed [RW-1:0] r,
                                                        input logic relu);
      logic signed [RW-1:0] v;
      v = r;
      if (relu && v < 0) v = '0;
      if (v > OMAX) v = OMAX;
      else if (v < OMIN) v = OMIN;
      return v[OUT_W-1:0];
   endfunction

   logic                    advance;
   logic                    accept;

   // window control (input side)
   logic [3:0]              in_cnt_q, in_cnt_d;
   logic [3:0]              rows_q;
   logic [4:0]              shift_q;
   logic                    relu_q;
   logic signed [ACC_W-1:0] bias_q;
   logic                    first_in, last_in;
   logic [3:0]              win_rows;
   logic [4:0]              win_shift;
   logic                    win_relu;
   logic signed [ACC_W-1:0] win_bias;

   // stage 0
   logic signed [PW-1:0]    prod_d [K];
   logic signed [PW-1:0]    prod_p0_q [K];
   logic                    vld_p0_q, first_p0_q, last_p0_q, relu_p0_q;
   logic [4:0]              shift_p0_q;
   logic signed [ACC_W-1:0] bias_p0_q;

   // stage 1
   logic signed [ACC_W-1:0] rowsum_d;
   logic signed [ACC_W-1:0] rowsum_p1_q;
   logic                    vld_p1_q, first_p1_q, last_p1_q, relu_p1_q;
   logic [4:0]              shift_p1_q;
   logic signed [ACC_W-1:0] bias_p1_q;

   // stage 2
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] accn_p2_q;
   logic                    vld_p2_q, relu_p2_q;
   logic [4:0]              shift_p2_q;

   // stage 3 (output)
   logic                    out_valid_q;
   logic signed [OUT_W-1:0] out_data_q;
   logic signed [ACC_W-1:0] out_acc_q;

   assign advance         = !(out_valid_q && !pe_if.out_ready);
   assign accept          = pe_if.in_valid && advance;
   assign pe_if.in_ready  = advance;
   assign pe_if.out_valid = out_valid_q;
   assign pe_if.out_data  = out_data_q;
   assign pe_if.out_acc   = out_acc_q;

   // Window config: live inputs on the first row, latched copy afterwards.
   always_comb begin
      first_in  = (in_cnt_q == 4'd0);
      win_rows  = first_in ? ((cfg_rows == 4'd0) ? 4'd1 : cfg_rows) : rows_q;
      win_shift = first_in ? cfg_shift : shift_q;
      win_relu  = first_in ? cfg_relu  : relu_q;
      win_bias  = first_in ? cfg_bias  : bias_q;
      last_in   = (in_cnt_q == win_rows - 4'd1);
      in_cnt_d  = last_in ? 4'd0 : in_cnt_q + 4'd1;
   end

   // Row counter and per-window config latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt_q <= '0;
         rows_q   <= '0;
         shift_q  <= '0;
         relu_q   <= 1'b0;
         bias_q   <= '0;
      end else if (accept) begin
         in_cnt_q <= in_cnt_d;
         if (first_in) begin
            rows_q  <= win_rows;
            shift_q <= win_shift;
            relu_q  <= win_relu;
            bias_q  <= win_bias;
         end
      end
   end

   // Per-tap signed products.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         prod_d[i] = PW'($signed(pe_if.in_data[i*DATA_W +: DATA_W])) *
                     PW'($signed(pe_if.weight[i*DATA_W +: DATA_W]));
      end
   end

   // Row reduction of the registered products.
   always_comb begin
      rowsum_d = '0;
      for (int i = 0; i < K; i++) rowsum_d = rowsum_d + ACC_W'(prod_p0_q[i]);
   end

   // Window accumulation; the first row restarts from the bias.
   always_comb acc_d = (first_p1_q ? bias_p1_q : acc_q) + rowsum_p1_q;

   // Stage valids, accumulator and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0_q    <= 1'b0;
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_acc_q   <= '0;
      end else if (advance) begin
         // ---- stage 0 -> 1 -> 2 valids
         vld_p0_q <= accept;
         vld_p1_q <= vld_p0_q;
         vld_p2_q <= vld_p1_q && last_p1_q;
         // ---- stage 2: accumulator
         if (vld_p1_q) acc_q <= last_p1_q ? '0 : acc_d;
         // ---- stage 3: requantised output
         out_valid_q <= vld_p2_q;
         if (vld_p2_q) begin
            out_acc_q  <= accn_p2_q;
            out_data_q <= saturate(round_shift(accn_p2_q, shift_p2_q), relu_p2_q);
         end
      end
   end

   // Datapath registers; qualified by the stage valids, so no reset needed.
   always_ff @(posedge clk) begin
      if (advance) begin
         // ---- stage 0
         for (int i = 0; i < K; i++) prod_p0_q[i] <= prod_d[i];
         first_p0_q  <= first_in;
         last_p0_q   <= last_in;
         shift_p0_q  <= win_shift;
         relu_p0_q   <= win_relu;
         bias_p0_q   <= win_bias;
         // ---- stage 1
         rowsum_p1_q <= rowsum_d;
         first_p1_q  <= first_p0_q;
         last_p1_q   <= last_p0_q;
         shift_p1_q  <= shift_p0_q;
         relu_p1_q   <= relu_p0_q;
         bias_p1_q   <= bias_p0_q;
         // ---- stage 2
         accn_p2_q   <= acc_d;
         shift_p2_q  <= shift_p1_q;
         relu_p2_q   <= relu_p1_q;
      end
   end

endmodule
